sr_latch_driver: RTL
====================

Name: sr_latch_driver

Overview:
- Synchronous sequencer that sits directly upstream of the gated SR latch and drives its S, R and En inputs.
- Turns single-cycle-sampled set/clear commands into a glitch-free drive sequence: S/R setup, then En pulse, then S/R hold.
- Reads back the latch outputs Q/notQ and reports completion plus a read-back fault.
- Used by lab top-levels and benches so the latch is never driven with S and R both active or with S/R changing while En is high.

Parameters:
- SETUP_CYC, 1, cycles S/R are held stable with En low before the enable pulse (legal 1..255; 0 behaves as 1).
- PULSE_CYC, 2, cycles En is held high (legal 1..255; 0 behaves as 1).
- HOLD_CYC, 1, cycles S/R stay stable after En falls (legal 1..255; 0 behaves as 1).

Ports:
- Clk  input  1  single system clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-high reset.
- SetReq  input  1  request to set the latch (Q=1); sampled only in IDLE.
- ClrReq  input  1  request to clear the latch (Q=0); sampled only in IDLE.
- Q  input  1  latch Q output (read-back).
- notQ  input  1  latch notQ output (read-back).
- S  output  1  latch set input, registered.
- R  output  1  latch reset input, registered.
- En  output  1  latch enable, registered.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse when a sequence completes.
- Fault  output  1  sticky read-back mismatch flag.
- Conflict  output  1  one-cycle pulse when SetReq and ClrReq are both high in IDLE.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high; it is sampled on the Clk rising edge and has priority over everything else.
- Reset values: state IDLE; S=R=En=0; Busy=Done=Fault=Conflict=0; counter=0.
- Output timing: all outputs are registered, with no combinational paths from inputs to outputs.
- States: IDLE, SETUP, PULSE, HOLD, CHECK. An internal op bit records 1=set, 0=clear. An 8-bit down-counter times each phase.
- IDLE:
  - SetReq xor ClrReq high at edge N → SETUP after edge N. Drive S=op, R=~op, En=0; clear Fault; load the counter.
  - Both high → Conflict=1 for one cycle, S/R/En stay 0, remain IDLE, no Done.
  - Neither high → stay IDLE.
- SETUP: lasts SETUP_CYC cycles, then PULSE.
- PULSE: En=1 for exactly PULSE_CYC cycles. S/R are unchanged.
- HOLD: En=0 for HOLD_CYC cycles. S/R are unchanged.
- CHECK (one cycle):
  - S=R=En=0; Q and notQ are sampled.
  - Mismatch is (Q != op) or (notQ == Q). On mismatch, Fault=1 after the edge leaving CHECK.
  - After that edge: Done=1 for one cycle; state returns to IDLE.
- Cycle accounting for a request sampled at edge N (defaults in brackets):
  - S or R rises after edge N.
  - En is high from edge N+SETUP_CYC to edge N+SETUP_CYC+PULSE_CYC [N+1 to N+3].
  - S/R fall after edge N+SETUP_CYC+PULSE_CYC+HOLD_CYC [N+4].
  - Done is high after edge N+SETUP_CYC+PULSE_CYC+HOLD_CYC+1 [N+5].
  - Busy is high from after edge N until Done rises.
- Invariants:
  - S and R are never both 1.
  - S/R never change on a cycle where En=1.
  - En is 0 in IDLE and CHECK.
- Requests while Busy are ignored, not queued. A new request may be accepted on the same edge that Done is asserted (back-to-back); Done and the new S/R then rise together.
- Fault:
  - Sticky until the next accepted command or Rst.
  - A Conflict does not clear Fault.
- Reset mid-sequence: Rst high at any edge forces the reset values immediately after that edge. No Done is produced for the aborted operation, and En drops in the same edge.

Test Plan:
- Rst=1 two cycles, then SetReq=1 for one cycle at edge N, latch model connected → S=1 after N; En=1 during cycles N+1..N+2; S=0 after N+4; Done=1 after N+5; Q=1, Fault=0.
- After the set, ClrReq pulse → R=1 and S=0 throughout; En high for 2 cycles; Done after 5 edges; Q=0, notQ=1, Fault=0.
- SetReq=ClrReq=1 in IDLE → Conflict=1 for exactly one cycle; S=R=En=0; Busy=0; no Done.
- Q read-back forced to 0 during a set → Fault=1 with Done; Fault stays 1 through idle cycles; the next ClrReq acceptance clears it.
- SetReq held high continuously → back-to-back sequences every 5 cycles; assert S&R never both 1 and S/R stable while En=1.
- Rst asserted during PULSE (En=1) → En=S=Busy=0 after that edge; no Done; next SetReq runs a full normal sequence.

Source files
------------

// File: rtl/sr_latch_driver_if.sv
// Signal bundle between the SR latch sequencer and the gated latch / request source.
interface sr_latch_driver_if;
    logic SetReq;
    logic ClrReq;
    logic Q;
    logic notQ;
    logic S;
    logic R;
    logic En;
    logic Busy;
    logic Done;
    logic Fault;
    logic Conflict;

    modport master (
        input  SetReq, ClrReq, Q, notQ,
        output S, R, En, Busy, Done, Fault, Conflict
    );

    modport slave (
        output SetReq, ClrReq, Q, notQ,
        input  S, R, En, Busy, Done, Fault, Conflict
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Sequences S/R setup, En pulse and S/R hold into a gated SR latch, then checks Q/notQ read-back.
module sr_latch_driver #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    sr_latch_driver_if.master   bus
);
    localparam int unsigned CNT_W = 8;

    // Zero-length phases are stretched to one cycle.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC == 0) ? 1 : SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'((PULSE_CYC == 0) ? 1 : PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC  == 0) ? 1 : HOLD_CYC);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             conflict_q, conflict_d;

    logic             can_accept_c;
    logic             start_c;
    logic             both_c;
    logic             drive_c;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            s_q        <= s_d;
            r_q        <= r_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        fault_d    = fault_q;
        done_d     = 1'b0;
        conflict_d = 1'b0;

        // Requests are taken in IDLE and on the CHECK exit edge, allowing back-to-back sequences.
        can_accept_c = (state_q == ST_IDLE) || (state_q == ST_CHECK);
        start_c      = can_accept_c && (bus.SetReq ^ bus.ClrReq);
        both_c       = can_accept_c && bus.SetReq && bus.ClrReq;

        if (start_c) begin
            state_d = ST_SETUP;
            op_d    = bus.SetReq;
            fault_d = 1'b0;
            cnt_d   = SETUP_LD;
        end
        if (both_c) begin
            conflict_d = 1'b1;
        end

        case (state_q)
            ST_SETUP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                done_d = 1'b1;
                // A read-back mismatch of the finishing op wins over a clear by a new accept.
                if ((bus.Q != op_q) || (bus.notQ == bus.Q)) begin
                    fault_d = 1'b1;
                end
                if (!start_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        drive_c = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
        s_d     = drive_c && op_d;
        r_d     = drive_c && !op_d;
        en_d    = (state_d == ST_PULSE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.En       = en_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Fault    = fault_q;
    assign bus.Conflict = conflict_q;

endmodule
